pspi_slave: RTL

Serial receiver/transmitter at the far end of the PSPI link. It consumes the master's serial data, serial clock and per-slave select line, and recovers each 8-bit frame (7 data bits plus 1 parity bit). It checks parity and presents the word to the slave-side logic. On the same clock edges it shifts a parity-protected response frame back to the master's serial input.

---
 rtl/pspi_slave.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pspi_slave.sv
// PSPI slave endpoint: synchronizes the master's serial lines, receives parity-checked
// frames and shifts a parity-protected response frame back out on miso.
module pspi_slave #(
  parameter int DATA_W      = 7,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              sel,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              frame_abort,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [7:0]        err_cnt
);

  localparam int   CW  = $clog2(DATA_W + 2);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [SYNC_STAGES-1:0] sclk_sync, sel_sync, mosi_sync;
  logic                sclk_prev, sel_prev;
  logic                sclk_s, sel_s, mosi_s;
  logic                sclk_rise, sclk_fall, sel_rise;
  logic [CW-1:0]       bit_cnt;
  logic [DATA_W-1:0]   tx_buf;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;
  logic [DATA_W:0]     rx_frame;
  logic [DATA_W:0]     tx_frame;
  logic [DATA_W-1:0]   load_val;
  logic                rx_bad;

  function automatic logic [DATA_W:0] make_frame(input logic [DATA_W-1:0] p);
    return {p, (^p) ^ ODD};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      sel_sync  <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      sel_prev  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], sel};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      sel_prev  <= sel_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sel_s     = sel_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign sel_rise  = sel_s & ~sel_prev;
  assign tx_ready  = (state == IDLE);

  // A load coinciding with the sel-rise detect must feed that same frame.
  always_comb begin
    load_val = (tx_load && state == IDLE) ? tx_data : tx_buf;
    tx_frame = make_frame(load_val);
    rx_frame = {rx_sh, mosi_s};
    rx_bad   = ((^rx_frame) != ODD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_buf      <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      frame_abort <= 1'b0;
      err_cnt     <= '0;
    end else begin
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      if (tx_load && state == IDLE) tx_buf <= tx_data;
      case (state)
        IDLE: begin
          miso    <= 1'b0;
          bit_cnt <= '0;
          if (sel_rise) begin
            state <= SHIFT;
            tx_sh <= tx_frame[DATA_W-1:0];
            miso  <= tx_frame[DATA_W];
          end
        end
        SHIFT: begin
          // sel low wins over a simultaneous final sclk rise.
          if (!sel_s) begin
            if (bit_cnt != '0) frame_abort <= 1'b1;
            state   <= IDLE;
            bit_cnt <= '0;
            miso    <= 1'b0;
          end else if (sclk_rise) begin
            rx_sh   <= rx_frame[DATA_W-1:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(DATA_W)) begin
              state    <= DONE;
              rx_data  <= rx_frame[DATA_W:1];
              rx_err   <= rx_bad;
              rx_valid <= 1'b1;
              if (rx_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            // The trailing fall of the previous frame lands at bit_cnt 0 and is skipped.
            miso  <= tx_sh[DATA_W-1];
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          end
        end
        DONE: begin
          bit_cnt <= '0;
          if (sel_s) begin
            state <= SHIFT;
            tx_sh <= tx_frame[DATA_W-1:0];
            miso  <= tx_frame[DATA_W];
          end else begin
            state <= IDLE;
            miso  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
